// File: rtl/display_ctrl.sv
// display_ctrl: chooses what the calculator screen shows. It can show the
// entry being keyed in, a freshly computed result held for a fixed time, or a
// manual scroll view driven by the left and right buttons.
// Optional feature macro: DISPLAY_CTRL_BLINK_EN makes the result blink while
// it is held. When the macro is undefined, blank_o is tied low.
// Handshake: a result transfers on a rising edge where result_valid_i and
// result_ready_o are both high. The producer holds result_valid_i and
// result_num_i steady until that edge. result_ready_o is combinational and is
// low while scrolling or in reset.

package calc_pkg;
    typedef logic [31:0] num_t;
endpackage

module display_ctrl #(
    parameter int HOLD_CYCLES    = 100_000_000,
    parameter int SCROLL_TIMEOUT = 250_000_000,
    parameter int BLINK_CYCLES   = 25_000_000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  calc_pkg::num_t entry_num_i,
    input  logic           entry_update_i,
    input  calc_pkg::num_t result_num_i,
    input  logic           result_valid_i,
    output logic           result_ready_o,
    input  logic           scroll_left_i,
    input  logic           scroll_right_i,
    output calc_pkg::num_t num_o,
    output logic           override_shift_amount_o,
    output logic [2:0]     new_shift_amount_o,
    output logic           blank_o,
    output logic [1:0]     dbg_state_o
);

    localparam int MAX_HS = (HOLD_CYCLES > SCROLL_TIMEOUT) ? HOLD_CYCLES : SCROLL_TIMEOUT;
    localparam int MAX_P  = (MAX_HS > BLINK_CYCLES) ? MAX_HS : BLINK_CYCLES;
    localparam int TW     = $clog2(MAX_P) + 1;
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] SCROLL_LOAD = TW'(SCROLL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SHOW_ENTRY  = 2'd0,
        SHOW_RESULT = 2'd1,
        SCROLL      = 2'd2
    } state_t;

    state_t         state, nxt_state;
    state_t         prev_view, nxt_prev_view;
    calc_pkg::num_t entry_q, nxt_entry;
    calc_pkg::num_t result_q, nxt_result;
    logic [2:0]     shift_q, nxt_shift;
    logic [TW-1:0]  timer_q, nxt_timer;
    logic           accept;
    logic           scroll_any;
    logic           nxt_show_result;

    assign accept         = result_valid_i && result_ready_o;
    assign scroll_any     = scroll_left_i || scroll_right_i;
    assign result_ready_o = !rst_i && (state != SCROLL);
    assign dbg_state_o    = state;

    // Next-state decode: result accept beats entry update, which beats scroll.
    always_comb begin
        nxt_state     = state;
        nxt_prev_view = prev_view;
        nxt_entry     = entry_q;
        nxt_result    = result_q;
        nxt_shift     = shift_q;
        nxt_timer     = timer_q;
        if (entry_update_i) begin
            nxt_entry = entry_num_i;
        end
        case (state)
            SCROLL: begin
                if (scroll_any) begin
                    nxt_timer = SCROLL_LOAD;
                    if (scroll_left_i && !scroll_right_i && shift_q != 3'd7) begin
                        nxt_shift = shift_q + 3'd1;
                    end else if (scroll_right_i && !scroll_left_i && shift_q != 3'd0) begin
                        nxt_shift = shift_q - 3'd1;
                    end
                end else if (timer_q == '0) begin
                    nxt_state = prev_view;
                    if (prev_view == SHOW_RESULT) begin
                        nxt_timer = HOLD_LOAD;
                    end
                end else begin
                    nxt_timer = timer_q - 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    nxt_result = result_num_i;
                    nxt_state  = SHOW_RESULT;
                    nxt_timer  = HOLD_LOAD;
                end else if (entry_update_i) begin
                    nxt_state = SHOW_ENTRY;
                    nxt_timer = '0;
                end else if (scroll_any) begin
                    nxt_prev_view = (state == SHOW_RESULT) ? SHOW_RESULT : SHOW_ENTRY;
                    nxt_state     = SCROLL;
                    nxt_shift     = scroll_left_i ? 3'd1 : 3'd0;
                    nxt_timer     = SCROLL_LOAD;
                end else if (state == SHOW_RESULT) begin
                    if (timer_q == '0) begin
                        nxt_state = SHOW_ENTRY;
                    end else begin
                        nxt_timer = timer_q - 1'b1;
                    end
                end
            end
        endcase
        nxt_show_result = (nxt_state == SHOW_RESULT) ||
                          (nxt_state == SCROLL && nxt_prev_view == SHOW_RESULT);
    end

    // State registers, with the outputs registered from the next-state values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                   <= SHOW_ENTRY;
            prev_view               <= SHOW_ENTRY;
            entry_q                 <= '0;
            result_q                <= '0;
            shift_q                 <= 3'd0;
            timer_q                 <= '0;
            num_o                   <= '0;
            override_shift_amount_o <= 1'b0;
            new_shift_amount_o      <= 3'd0;
        end else begin
            state                   <= nxt_state;
            prev_view               <= nxt_prev_view;
            entry_q                 <= nxt_entry;
            result_q                <= nxt_result;
            shift_q                 <= nxt_shift;
            timer_q                 <= nxt_timer;
            num_o                   <= nxt_show_result ? nxt_result : nxt_entry;
            override_shift_amount_o <= (nxt_state == SCROLL);
            new_shift_amount_o      <= (nxt_state == SCROLL) ? nxt_shift : 3'd0;
        end
    end

`ifdef DISPLAY_CTRL_BLINK_EN
    localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_CYCLES - 1);
    logic [TW-1:0] blink_q;
    logic          blank_q;
    logic          hold_load;

    // A hold (re)starts when the result view is entered or a new result is accepted.
    assign hold_load = (nxt_state == SHOW_RESULT) && (state != SHOW_RESULT || accept);
    assign blank_o   = blank_q;

    // Blink phase: visible for BLINK_CYCLES, then blank for BLINK_CYCLES, and so on.
    always_ff @(posedge clk_i) begin
        if (rst_i || nxt_state != SHOW_RESULT) begin
            blink_q <= '0;
            blank_q <= 1'b0;
        end else if (hold_load) begin
            blink_q <= BLINK_LOAD;
            blank_q <= 1'b0;
        end else if (blink_q == '0) begin
            blink_q <= BLINK_LOAD;
            blank_q <= !blank_q;
        end else begin
            blink_q <= blink_q - 1'b1;
        end
    end
`else
    assign blank_o = 1'b0;
`endif

endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl with short timing parameters. Each driven
// cycle queues the outputs expected after the next rising edge. A monitor
// pops one entry per edge and compares it against the DUT.

module tb_display_ctrl;

    localparam int HOLD   = 8;
    localparam int SCROLL = 6;
    localparam int BLINK  = 2;
`ifdef DISPLAY_CTRL_BLINK_EN
    localparam logic BLINK_ON = 1'b1;
`else
    localparam logic BLINK_ON = 1'b0;
`endif

    localparam logic [31:0] E1 = 32'h0000_0042;
    localparam logic [31:0] E2 = 32'h0000_1234;
    localparam logic [31:0] E4 = 32'h0000_0777;
    localparam logic [31:0] R1 = 32'h0003_1400;
    localparam logic [31:0] R2 = 32'h0002_7182;
    localparam logic [31:0] R3 = 32'h0001_4142;
    localparam logic [31:0] R4 = 32'h0000_0099;
    localparam logic [31:0] R5 = 32'h00AB_CDEF;
    localparam logic [31:0] R6 = 32'h0055_AA55;
    localparam logic [31:0] R7 = 32'h0000_0001;

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] entry_num = '0;
    logic        entry_update = 1'b0;
    logic [31:0] result_num = '0;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic        scroll_left = 1'b0;
    logic        scroll_right = 1'b0;
    logic [31:0] num;
    logic        override_shift;
    logic [2:0]  new_shift;
    logic        blank;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    display_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .SCROLL_TIMEOUT (SCROLL),
        .BLINK_CYCLES   (BLINK)
    ) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .entry_num_i             (entry_num),
        .entry_update_i          (entry_update),
        .result_num_i            (result_num),
        .result_valid_i          (result_valid),
        .result_ready_o          (result_ready),
        .scroll_left_i           (scroll_left),
        .scroll_right_i          (scroll_right),
        .num_o                   (num),
        .override_shift_amount_o (override_shift),
        .new_shift_amount_o      (new_shift),
        .blank_o                 (blank),
        .dbg_state_o             (dbg_state)
    );

    // Scoreboard: {num, override, shift, blank, ready}
    logic [37:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic blink_at(input int k);
        return ((k / BLINK) % 2) != 0;
    endfunction

    // Driver: apply one cycle of inputs on the falling edge and queue its expectation
    task automatic drive(input string name, input logic r, input logic v, input logic [31:0] rn,
                         input logic eu, input logic [31:0] en, input logic sl, input logic sr,
                         input logic [31:0] e_num, input logic e_ovr, input logic [2:0] e_sh,
                         input logic e_blank, input logic e_rdy);
        @(negedge clk);
        rst          = r;
        result_valid = v;
        result_num   = rn;
        entry_update = eu;
        entry_num    = en;
        scroll_left  = sl;
        scroll_right = sr;
        exp_q.push_back({e_num, e_ovr, e_sh, e_blank & BLINK_ON, e_rdy});
        name_q.push_back(name);
    endtask

    task automatic idle(input string name, input logic [31:0] e_num, input logic e_ovr,
                        input logic [2:0] e_sh, input logic e_blank, input logic e_rdy);
        drive(name, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, e_num, e_ovr, e_sh, e_blank, e_rdy);
    endtask

    // Monitor: compare one queued expectation just after every rising edge
    initial begin
        logic [37:0] exp_v;
        logic [37:0] act_v;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {num, override_shift, new_shift, blank, result_ready};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got num=%h ovr=%b shift=%0d blank=%b ready=%b, want num=%h ovr=%b shift=%0d blank=%b ready=%b",
                             nm, act_v[37:6], act_v[5], act_v[4:2], act_v[1], act_v[0],
                             exp_v[37:6], exp_v[5], exp_v[4:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        drive("reset0", 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0, 1'b0, 1'b0);
        drive("reset1", 1'b1, 1'b1, R1, 1'b1, E1, 1'b1, 1'b0, '0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle("post_reset", '0, 1'b0, 3'd0, 1'b0, 1'b1);

        // Entry update then a single-cycle result, held for HOLD cycles
        drive("entry_e1", 1'b0, 1'b0, '0, 1'b1, E1, 1'b0, 1'b0, E1, 1'b0, 3'd0, 1'b0, 1'b1);
        drive("accept_r1", 1'b0, 1'b1, R1, 1'b0, '0, 1'b0, 1'b0, R1, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int k = 1; k < HOLD; k++) idle("hold_r1", R1, 1'b0, 3'd0, blink_at(k), 1'b1);
        idle("hold_r1_end", E1, 1'b0, 3'd0, 1'b0, 1'b1);

        // Entry update in the middle of a hold returns to the entry view
        drive("accept_r2", 1'b0, 1'b1, R2, 1'b0, '0, 1'b0, 1'b0, R2, 1'b0, 3'd0, 1'b0, 1'b1);
        idle("hold_r2", R2, 1'b0, 3'd0, blink_at(1), 1'b1);
        idle("hold_r2", R2, 1'b0, 3'd0, blink_at(2), 1'b1);
        drive("entry_cut", 1'b0, 1'b0, '0, 1'b1, E2, 1'b0, 1'b0, E2, 1'b0, 3'd0, 1'b0, 1'b1);
        idle("entry_view", E2, 1'b0, 3'd0, 1'b0, 1'b1);

        // Nine left pulses from the entry view: shift saturates at 7
        for (int i = 1; i <= 9; i++)
            drive("scroll_left", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, E2, 1'b1,
                  (i > 7) ? 3'd7 : 3'(i), 1'b0, 1'b0);
        for (int i = 0; i < SCROLL - 1; i++) idle("scroll_wait", E2, 1'b1, 3'd7, 1'b0, 1'b0);
        idle("scroll_timeout", E2, 1'b0, 3'd0, 1'b0, 1'b1);

        // Scroll from the result view; right saturates at 0, both buttons at once hold the shift
        drive("accept_r3", 1'b0, 1'b1, R3, 1'b0, '0, 1'b0, 1'b0, R3, 1'b0, 3'd0, 1'b0, 1'b1);
        drive("scroll_enter_r", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, R3, 1'b1, 3'd0, 1'b0, 1'b0);
        drive("scroll_l", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, R3, 1'b1, 3'd1, 1'b0, 1'b0);
        drive("scroll_both", 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, R3, 1'b1, 3'd1, 1'b0, 1'b0);
        drive("scroll_r", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, R3, 1'b1, 3'd0, 1'b0, 1'b0);
        drive("scroll_r_sat", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, R3, 1'b1, 3'd0, 1'b0, 1'b0);
        // A result offered while scrolling waits for the timeout
        for (int i = 0; i < SCROLL - 1; i++)
            drive("scroll_blocks", 1'b0, 1'b1, R4, 1'b0, '0, 1'b0, 1'b0, R3, 1'b1, 3'd0, 1'b0, 1'b0);
        drive("scroll_back_res", 1'b0, 1'b1, R4, 1'b0, '0, 1'b0, 1'b0, R3, 1'b0, 3'd0, 1'b0, 1'b1);
        drive("accept_after", 1'b0, 1'b1, R4, 1'b0, '0, 1'b0, 1'b0, R4, 1'b0, 3'd0, 1'b0, 1'b1);
        idle("hold_r4", R4, 1'b0, 3'd0, blink_at(1), 1'b1);

        // Result, entry and scroll in one cycle: result wins, entry still captured
        drive("prio_all", 1'b0, 1'b1, R5, 1'b1, E4, 1'b1, 1'b0, R5, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int k = 1; k < HOLD; k++) idle("hold_r5", R5, 1'b0, 3'd0, blink_at(k), 1'b1);
        idle("entry_captured", E4, 1'b0, 3'd0, 1'b0, 1'b1);

        // Reset in the middle of a hold; the pending result is not taken during reset
        drive("accept_r6", 1'b0, 1'b1, R6, 1'b0, '0, 1'b0, 1'b0, R6, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int k = 1; k < 4; k++) idle("hold_r6", R6, 1'b0, 3'd0, blink_at(k), 1'b1);
        drive("mid_reset", 1'b1, 1'b1, R7, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 3'd0, 1'b0, 1'b0);
        drive("accept_r7", 1'b0, 1'b1, R7, 1'b0, '0, 1'b0, 1'b0, R7, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int k = 1; k < HOLD; k++) idle("hold_r7", R7, 1'b0, 3'd0, blink_at(k), 1'b1);
        idle("entry_cleared", '0, 1'b0, 3'd0, 1'b0, 1'b1);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
